// File: rtl/seg_pkg.sv
// seg_pkg: constants shared by the seven-segment display driver.
//   - Segment bit positions on the active-low segment bus (a..g, dp).
//   - Whole-bus patterns: all dark, all lit, dash.
//   - 16-entry BCD-to-segment table. Codes 10..15 map to a dash.
//     In every table entry bit7 (dp) is off.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ALL   = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Packed table: the left-most element is index 15, the right-most is index 0.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,   // 15..10
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,                            // 9..5
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0                             // 4..0
  };

endpackage

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode: combinational BCD to active-low seven-segment decoder.
//   code  : 4-bit BCD digit. Codes 10..15 are invalid and show a dash.
//   blank : 1 turns segments a..g off. The decimal point is not affected.
//   dp    : 1 lights the decimal point (bit7 driven low).
//   seg_n : active-low segment pattern. bit0..6 = a..g, bit7 = dp.
module seg_bcd_decode (
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg_n
);
  import seg_pkg::*;

  always_comb begin
    seg_n = SEG_TABLE[code];
    if (blank) begin
      seg_n[SEG_G:SEG_A] = SEG_BLANK[SEG_G:SEG_A];
    end
    seg_n[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment display driver.
//   clk, rst_n : clock and asynchronous active-low reset.
//   digits_in  : packed BCD input. Digit k is at [4k+3:4k]; digit 0 is least significant.
//   load       : one-cycle strobe. Captures digits_in and dp_in into the shadow registers.
//   dp_in      : per-digit decimal point request. Captured together with load.
//   blank_lead : level input. Enables leading-zero suppression.
//   alarm      : level input. Replaces scanning with a blinking all-on pattern on all digits.
//   seg_n      : active-low segment bus. bit0..6 = a..g, bit7 = dp.
//   dig_sel_n  : active-low digit enables. While scanning, exactly one bit is low.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lead,
  input  logic                    alarm,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_sel_n
);
  import seg_pkg::*;

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] shadow_bcd_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [SCAN_W-1:0]       scan_cnt_reg;
  logic [BLINK_W-1:0]      blink_cnt_reg;
  logic                    blink_on_reg;
  logic [7:0]              seg_n_reg;
  logic [NUM_DIGITS-1:0]   dig_sel_n_reg;

  logic [7:0]              seg_n_next;
  logic [NUM_DIGITS-1:0]   dig_sel_n_next;

  // zero_from[k] is 1 when digit k and every more significant digit are 0.
  // The top entry seeds the chain. Invalid codes are non-zero, so they stop the chain.
  logic [NUM_DIGITS:0]     zero_from;
  logic [NUM_DIGITS-1:0]   blank_mask;

  assign zero_from[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign zero_from[gi] = (shadow_bcd_reg[4*gi +: 4] == 4'd0) && zero_from[gi+1];
      if (gi == 0) begin : g_units
        // The units digit always shows, so a zero value still displays "0".
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = blank_lead && zero_from[gi];
      end
    end
  endgenerate

  // Select the current digit. The decoder then runs once on the selected digit.
  logic [3:0] sel_code;
  logic       sel_blank;
  logic       sel_dp;
  logic [7:0] dec_seg_n;

  always_comb begin
    sel_code  = 4'd0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        sel_code  = shadow_bcd_reg[4*k +: 4];
        sel_blank = blank_mask[k];
        sel_dp    = shadow_dp_reg[k];
      end
    end
  end

  seg_bcd_decode u_decode (
    .code  (sel_code),
    .blank (sel_blank),
    .dp    (sel_dp),
    .seg_n (dec_seg_n)
  );

  always_comb begin
    if (alarm) begin
      dig_sel_n_next = '0;
      seg_n_next     = blink_on_reg ? SEG_ALL : SEG_BLANK;
    end else begin
      dig_sel_n_next = ~(NUM_DIGITS'(1) << idx_reg);
      seg_n_next     = dec_seg_n;
    end
  end

  // Shadow registers. Data written here appears on the pins one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd_reg <= '0;
      shadow_dp_reg  <= '0;
    end else if (load) begin
      shadow_bcd_reg <= digits_in;
      shadow_dp_reg  <= dp_in;
    end
  end

  // The scan counter keeps running during alarm.
  // This lets the display resume at the same position the scan has reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  // The blink counter runs only during alarm.
  // When alarm is low it is held at 0 with the phase on, so every alarm starts with a full lit half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (!alarm) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= ~blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_reg     <= SEG_BLANK;
      dig_sel_n_reg <= '1;
    end else begin
      seg_n_reg     <= seg_n_next;
      dig_sel_n_reg <= dig_sel_n_next;
    end
  end

  assign seg_n     = seg_n_reg;
  assign dig_sel_n = dig_sel_n_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=4 and BLINK_DIV=8.
// The reference model does not track counters.
// It derives the expected pins from the number of edges since reset:
//   - scanned digit = ((edges-1)/SCAN_DIV) mod NUM_DIGITS
//   - blink phase   = ((alarm_run-1)/BLINK_DIV) mod 2
// The model also keeps a copy of the last loaded word.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*ND-1:0] digits_in;
  logic          load;
  logic [ND-1:0] dp_in;
  logic          blank_lead;
  logic          alarm;
  logic [7:0]    seg_n;
  logic [ND-1:0] dig_sel_n;

  int compared   = 0;
  int mismatched = 0;

  // Model state
  int            edge_cnt;   // edges since reset release
  int            alarm_run;  // consecutive edges with alarm sampled high
  logic [15:0]   m_bcd;
  logic [3:0]    m_dp;
  int            step_no = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_lead (blank_lead),
    .alarm      (alarm),
    .seg_n      (seg_n),
    .dig_sel_n  (dig_sel_n)
  );

  always #5 clk = ~clk;

  // Expected pins after edge number en, given the alarm run length ar at that edge.
  function automatic void expect_out(input int en, input int ar,
                                     output logic [7:0] es, output logic [3:0] ed);
    int  idx;
    bit  all_zero;
    logic [3:0] code;
    if (alarm) begin
      ed = 4'h0;
      es = ((((ar - 1) / BD) % 2) == 0) ? 8'h00 : 8'hFF;
    end else begin
      idx = ((en - 1) / SD) % ND;
      code = m_bcd[4*idx +: 4];
      all_zero = 1'b1;
      for (int j = idx; j < ND; j++) begin
        if (m_bcd[4*j +: 4] != 4'd0) all_zero = 1'b0;
      end
      if (blank_lead && idx != 0 && all_zero) es = 8'hFF;
      else es = seg_tab[code];
      es[7] = ~m_dp[idx];
      ed = ~(4'b0001 << idx);
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] es, input logic [3:0] ed);
    compared++;
    assert (seg_n === es) else begin
      mismatched++;
      $error("FAIL %s seg_n: observed %h expected %h", tag, seg_n, es);
    end
    compared++;
    assert (dig_sel_n === ed) else begin
      mismatched++;
      $error("FAIL %s dig_sel_n: observed %h expected %h", tag, dig_sel_n, ed);
    end
  endtask

  // One clock cycle: predict, clock, update the model, then compare at the negedge.
  task automatic step(input string tag);
    logic [7:0] es;
    logic [3:0] ed;
    int en;
    int ar;
    en = edge_cnt + 1;
    ar = alarm ? alarm_run + 1 : 0;
    expect_out(en, ar, es, ed);
    @(posedge clk);
    edge_cnt  = en;
    alarm_run = ar;
    if (load) begin
      m_bcd = digits_in;
      m_dp  = dp_in;
    end
    @(negedge clk);
    step_no++;
    check($sformatf("%s#%0d", tag, step_no), es, ed);
    $display("step %0d %s: load=%b alarm=%b blank=%b seg_n=%h dig_sel_n=%h",
             step_no, tag, load, alarm, blank_lead, seg_n, dig_sel_n);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic load_word(input logic [15:0] w, input logic [3:0] d, input string tag);
    digits_in = w;
    dp_in     = d;
    load      = 1'b1;
    step(tag);
    load      = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < ND; k++) begin
      w[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; load = 1'b0; alarm = 1'b0; blank_lead = 1'b0;
    digits_in = '0; dp_in = '0;
    edge_cnt = 0; alarm_run = 0; m_bcd = '0; m_dp = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 8'hFF, 4'hF);
    rst_n = 1'b1;

    // Basic scan
    load_word(16'h1234, 4'b0000, "load1234");
    run(32, "scan1234");

    // Leading-zero blanking
    blank_lead = 1'b1;
    load_word(16'h0050, 4'b0000, "load0050");
    run(16, "blank0050");
    load_word(16'h0000, 4'b0000, "load0000");
    run(16, "blank0000");

    // Invalid codes, dp on a dash, blanking does not affect invalid digits
    blank_lead = 1'b0;
    load_word(16'h9A0F, 4'b0100, "load9A0F");
    run(16, "dash");
    blank_lead = 1'b1;
    run(16, "dash_blank");

    // Random loads, dp and blanking
    for (int i = 0; i < 60; i++) begin
      blank_lead = ($urandom_range(0, 7) == 0) ? ~blank_lead : blank_lead;
      if ($urandom_range(0, 3) == 0) load_word(rand_word(), 4'($urandom_range(0, 15)), "rnd_load");
      else step("rnd");
    end

    // Alarm raised mid-scan, load while alarm is high, then release
    run(2, "pre_alarm");
    alarm = 1'b1;
    run(20, "alarm");
    load_word(16'h5678, 4'b0000, "alarm_load");
    run(19, "alarm");
    alarm = 1'b0;
    run(20, "post_alarm");

    // Random alarm toggling together with random loads
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) alarm = ~alarm;
      if ($urandom_range(0, 5) == 0) load_word(rand_word(), 4'($urandom_range(0, 15)), "mix_load");
      else step("mix");
    end
    alarm = 1'b0;
    run(3, "settle");

    // Asynchronous reset in the middle of a slot
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'hFF, 4'hF);
    edge_cnt = 0; alarm_run = 0; m_bcd = '0; m_dp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    blank_lead = 1'b0;
    run(16, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
